// File: rtl/mcash_xbar_ch_arbiter.sv
// Round-robin arbiter that shares the cross-bar request port among NUM_CH channels,
// with a 1-entry registered output stage. Define MCASH_XBAR_ARB_PERF_EN for perf counters.
module mcash_xbar_ch_arbiter #(
    parameter int NUM_CH = 4,
    parameter int OP_W   = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int CHID_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_req_valid_i,
    output logic [NUM_CH-1:0]          ch_req_allowIn_o,
    input  logic [NUM_CH*OP_W-1:0]     ch_req_op_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]   ch_req_data_i,
    output logic                       xbar_req_valid_o,
    input  logic                       xbar_req_allowIn_i,
    output logic [CHID_W-1:0]          xbar_req_chid_o,
    output logic [OP_W-1:0]            xbar_req_op_o,
    output logic [ADDR_W-1:0]          xbar_req_addr_o,
    output logic [DATA_W-1:0]          xbar_req_data_o
`ifdef MCASH_XBAR_ARB_PERF_EN
    ,
    output logic [NUM_CH*32-1:0]       perf_grant_cnt_o,
    output logic [31:0]                perf_stall_cnt_o
`endif
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic [CHID_W-1:0] chid;
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic [NUM_CH-1:0][OP_W-1:0]   op_arr;
    logic [NUM_CH-1:0][ADDR_W-1:0] addr_arr;
    logic [NUM_CH-1:0][DATA_W-1:0] data_arr;

    assign op_arr   = ch_req_op_i;
    assign addr_arr = ch_req_addr_i;
    assign data_arr = ch_req_data_i;

    logic             out_vld;
    req_t             out_req;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_nxt;
    logic             slot_free;
    logic             gnt_vld;
    logic [PTR_W-1:0] gnt_id;
    logic [PTR_W:0]   rot_sum;
    logic [PTR_W-1:0] rot_idx;

    assign slot_free = !out_vld || xbar_req_allowIn_i;

    // Scan channels starting at rr_ptr; the extra sum bit keeps the wrap exact for any NUM_CH.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        rot_sum = '0;
        rot_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rot_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (rot_sum >= (PTR_W+1)'(NUM_CH))
                rot_sum = rot_sum - (PTR_W+1)'(NUM_CH);
            rot_idx = rot_sum[PTR_W-1:0];
            if (!gnt_vld && ch_req_valid_i[rot_idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = rot_idx;
            end
        end
        // Reset must hold every accept low even though the empty stage looks free.
        gnt_vld = gnt_vld && slot_free && rst_n;
    end

    assign rr_nxt           = (gnt_id == PTR_W'(NUM_CH-1)) ? '0 : gnt_id + 1'b1;
    assign ch_req_allowIn_o = gnt_vld ? (NUM_CH'(1) << gnt_id) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            rr_ptr  <= '0;
            out_req <= '0;
        end else if (gnt_vld) begin
            out_vld      <= 1'b1;
            rr_ptr       <= rr_nxt;
            out_req.chid <= CHID_W'(gnt_id);
            out_req.op   <= op_arr[gnt_id];
            out_req.addr <= addr_arr[gnt_id];
            out_req.data <= data_arr[gnt_id];
        end else if (xbar_req_allowIn_i) begin
            out_vld <= 1'b0;
        end
    end

    assign xbar_req_valid_o = out_vld;
    assign xbar_req_chid_o  = out_req.chid;
    assign xbar_req_op_o    = out_req.op;
    assign xbar_req_addr_o  = out_req.addr;
    assign xbar_req_data_o  = out_req.data;

`ifdef MCASH_XBAR_ARB_PERF_EN
    logic [NUM_CH-1:0][31:0] grant_cnt;
    logic [31:0]             stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (gnt_vld)
                grant_cnt[gnt_id] <= grant_cnt[gnt_id] + 32'd1;
            if (out_vld && !xbar_req_allowIn_i)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_grant_cnt_o = grant_cnt;
    assign perf_stall_cnt_o = stall_cnt;
`endif

    a_allow_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(ch_req_allowIn_o));
    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        out_vld && !xbar_req_allowIn_i |=> out_vld && $stable(out_req));

endmodule

// File: tb/tb_mcash_xbar_ch_arbiter.sv
// Directed bench for mcash_xbar_ch_arbiter: a per-cycle round-robin reference model
// plus hand-computed literal checks for each scenario.
module tb_mcash_xbar_ch_arbiter;
    localparam int N = 4, OP_W = 3, ADDR_W = 32, DATA_W = 64, CHID_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]             valid;
    logic [N-1:0]             allow;
    logic [N-1:0][OP_W-1:0]   op;
    logic [N-1:0][ADDR_W-1:0] addr;
    logic [N-1:0][DATA_W-1:0] data;
    logic                     x_vld, x_allow;
    logic [CHID_W-1:0]        x_chid;
    logic [OP_W-1:0]          x_op;
    logic [ADDR_W-1:0]        x_addr;
    logic [DATA_W-1:0]        x_data;
`ifdef MCASH_XBAR_ARB_PERF_EN
    logic [N-1:0][31:0]       perf_gcnt;
    logic [31:0]              perf_stall;
`endif

    mcash_xbar_ch_arbiter #(.NUM_CH(N), .OP_W(OP_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                            .CHID_W(CHID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_req_valid_i(valid), .ch_req_allowIn_o(allow),
        .ch_req_op_i(op), .ch_req_addr_i(addr), .ch_req_data_i(data),
        .xbar_req_valid_o(x_vld), .xbar_req_allowIn_i(x_allow),
        .xbar_req_chid_o(x_chid), .xbar_req_op_o(x_op),
        .xbar_req_addr_o(x_addr), .xbar_req_data_o(x_data)
`ifdef MCASH_XBAR_ARB_PERF_EN
        , .perf_grant_cnt_o(perf_gcnt), .perf_stall_cnt_o(perf_stall)
`endif
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: what the output stage holds, the RR pointer, and counters.
    bit               m_vld, n_vld;
    int               m_chid, n_chid, m_rr, n_rr, n_gnt;
    logic [OP_W-1:0]  m_op, n_op;
    logic [ADDR_W-1:0] m_addr, n_addr;
    logic [DATA_W-1:0] m_data, n_data;
    bit               n_stall;
    int               m_gcnt[N];
    int               m_stall;
    int               gnt_log[$];

    always @(negedge clk) begin
        int g;
        logic [N-1:0] ea;
        if (!rst_n) begin
            m_vld = 0; m_chid = 0; m_rr = 0; m_op = '0; m_addr = '0; m_data = '0;
            n_vld = 0; n_chid = 0; n_rr = 0; n_op = '0; n_addr = '0; n_data = '0;
            n_gnt = -1; n_stall = 0; m_stall = 0;
            for (int k = 0; k < N; k++) m_gcnt[k] = 0;
            chk("rst_allow", allow, 0);
            chk("rst_xvalid", x_vld, 0);
        end else begin
            g = -1;
            if (!m_vld || x_allow)
                for (int i = 0; i < N; i++)
                    if (g < 0 && valid[(m_rr + i) % N]) g = (m_rr + i) % N;
            ea = '0;
            if (g >= 0) ea[g] = 1'b1;
            chk("allow", allow, ea);
            chk("xvalid", x_vld, m_vld);
            if (m_vld) begin
                chk("xchid", x_chid, m_chid);
                chk("xop", x_op, m_op);
                chk("xaddr", x_addr, m_addr);
                chk("xdata", x_data, m_data);
            end
`ifdef MCASH_XBAR_ARB_PERF_EN
            for (int k = 0; k < N; k++) chk("perf_gcnt", perf_gcnt[k], m_gcnt[k]);
            chk("perf_stall", perf_stall, m_stall);
`endif
            for (int k = 0; k < N; k++) if (allow[k]) gnt_log.push_back(k);
            n_vld = m_vld; n_chid = m_chid; n_rr = m_rr;
            n_op = m_op; n_addr = m_addr; n_data = m_data;
            n_gnt = g; n_stall = m_vld && !x_allow;
            if (g >= 0) begin
                n_vld = 1; n_chid = g; n_rr = (g + 1) % N;
                n_op = op[g]; n_addr = addr[g]; n_data = data[g];
            end else if (x_allow) begin
                n_vld = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_vld = n_vld; m_chid = n_chid; m_rr = n_rr;
            m_op = n_op; m_addr = n_addr; m_data = n_data;
            if (n_gnt >= 0) m_gcnt[n_gnt]++;
            if (n_stall) m_stall++;
            n_gnt = -1; n_stall = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        valid = '1; x_allow = 1'b1;
        for (int k = 0; k < N; k++) begin
            op[k]   = OP_W'(k + 1);
            addr[k] = 32'h100 * k + 32'h40;
            data[k] = {32'hD0D0_0000, 32'(k)};
        end
        // 1: reset with all channels requesting
        repeat (3) @(posedge clk);
        #1;
        chk("s1_rst_allow", allow, 0);
        chk("s1_rst_xvalid", x_vld, 0);
        gnt_log.delete();
        rst_n = 1'b1;
        #1 chk("s1_first_grant", allow, 4'b0001);
        @(posedge clk); #1;
        chk("s1_xvalid", x_vld, 1);
        chk("s1_chid", x_chid, 0);
        // 2: continuous full load, RR order
        cyc = 0;
        while (gnt_log.size() < 8 && cyc < 40) begin @(posedge clk); cyc++; end
        #1;
        if (cyc >= 40) chk("s2_timeout", gnt_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("s2_order", gnt_log[i], i % 4);
        valid = '0;
        repeat (2) @(posedge clk);
        #1;
        // 3: backpressure holding ch2's request
        addr[2] = 32'h1000;
        valid = 4'b0100;
        #1 chk("s3_grant2", allow, 4'b0100);
        @(posedge clk); #1;
        x_allow = 1'b0;
        valid = '1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s3_hold_allow", allow, 0);
            chk("s3_hold_addr", x_addr, 32'h1000);
            chk("s3_hold_vld", x_vld, 1);
            @(posedge clk); #1;
        end
        x_allow = 1'b1;
        #1 chk("s3_next_rr", allow, 4'b1000);
        @(posedge clk); #1;
        chk("s3_chid3", x_chid, 3);
        valid = '0;
`ifdef MCASH_XBAR_ARB_PERF_EN
        chk("s6_g0", perf_gcnt[0], 2);
        chk("s6_g1", perf_gcnt[1], 2);
        chk("s6_g2", perf_gcnt[2], 3);
        chk("s6_g3", perf_gcnt[3], 3);
        chk("s6_stall", perf_stall, 5);
`endif
        repeat (2) @(posedge clk);
        #1;
        // 4: sparse requesters, ch3 then ch1
        valid = 4'b1000;
        #1 chk("s4_grant3", allow, 4'b1000);
        @(posedge clk); #1;
        valid = 4'b0010;
        #1 chk("s4_grant1", allow, 4'b0010);
        @(posedge clk); #1;
        chk("s4_chid1", x_chid, 1);
        valid = '0;
        @(posedge clk); #1;
        // 5: async reset while a request is held
        op[1] = 3'b010;
        valid = 4'b0010;
        x_allow = 1'b0;
        @(posedge clk); #1;
        chk("s5_held_vld", x_vld, 1);
        chk("s5_held_op", x_op, 3'b010);
        valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_vld", x_vld, 0);
        chk("s5_rst_op", x_op, 0);
        chk("s5_rst_chid", x_chid, 0);
        @(posedge clk); #1;
        x_allow = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("s5_no_replay", x_vld, 0);
        end
        valid = 4'b0100;
        #1 chk("s5_new_grant", allow, 4'b0100);
        @(posedge clk); #1;
        chk("s5_new_chid", x_chid, 2);
        valid = '0;
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
